button_debouncer: RTL and testbench

- Debounces and edge-qualifies N raw pushbutton/switch inputs for the register I/O block.
- Sits directly downstream of the 25 MHz sample-strobe generator. That generator emits a 6-cycle-high pulse once every 501 cycles (≈49.9 kHz, one period ≈20.04 µs).
- Detects the rising edge of that strobe, so each strobe counts exactly once.
- Produces stable levels plus one-cycle press, release and long-press pulses for the register file.

---
 rtl/button_debouncer_if.sv | 30 +++
 rtl/button_debouncer.sv | 139 +++++++++++++
 tb/tb_button_debouncer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Button debouncer port bundle: strobe and raw levels in,
// debounced levels and event pulses out.
interface button_debouncer_if #(
  parameter int N = 4
);
  logic         tick;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_stable;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;

  modport master (
    output tick,
    output btn_raw,
    input  btn_stable,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  tick,
    input  btn_raw,
    output btn_stable,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/button_debouncer.sv
// N-channel pushbutton debouncer with strobe-edge sampling,
// press/release pulses and a one-shot long-press pulse.
module button_debouncer #(
  parameter int N            = 4,
  parameter int STABLE_TICKS = 250,
  parameter int HOLD_TICKS   = 25000
) (
  input  logic               clk25mhz,
  input  logic               rst_n,
  button_debouncer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_REL,
    S_PRESS_PEND,
    S_PRS,
    S_REL_PEND
  } state_t;

  localparam logic [9:0]  ST = 10'(STABLE_TICKS);
  localparam logic [15:0] HT = 16'(HOLD_TICKS);

  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;
  logic         r_tick_d;
  logic         w_rise;

  state_t       r_state   [N];
  state_t       w_state_nx[N];
  logic [9:0]   r_db      [N];
  logic [9:0]   w_db_nx   [N];
  logic [15:0]  r_hold    [N];
  logic [15:0]  w_hold_nx [N];

  logic [N-1:0] r_stable;
  logic [N-1:0] r_press;
  logic [N-1:0] r_release;
  logic [N-1:0] r_long;
  logic [N-1:0] w_stable_nx;
  logic [N-1:0] w_press_nx;
  logic [N-1:0] w_release_nx;
  logic [N-1:0] w_long_nx;

  assign w_rise = bus.tick & ~r_tick_d;

  always_comb begin
    w_stable_nx  = r_stable;
    w_press_nx   = '0;
    w_release_nx = '0;
    w_long_nx    = '0;
    for (int i = 0; i < N; i++) begin
      w_state_nx[i] = r_state[i];
      w_db_nx[i]    = r_db[i];
      w_hold_nx[i]  = r_hold[i];
      if (w_rise) begin
        // hold_cnt saturates at HT so the long pulse fires once per press
        if ((r_state[i] == S_PRS || r_state[i] == S_REL_PEND)
            && r_hold[i] != HT) begin
          w_hold_nx[i] = r_hold[i] + 16'd1;
          if (r_hold[i] + 16'd1 == HT)
            w_long_nx[i] = 1'b1;
        end
        unique case (r_state[i])
          S_REL, S_PRESS_PEND: begin
            if (r_sync2[i]) begin
              if (r_db[i] + 10'd1 == ST) begin
                w_stable_nx[i] = 1'b1;
                w_press_nx[i]  = 1'b1;
                w_db_nx[i]     = '0;
                w_hold_nx[i]   = '0;
                w_state_nx[i]  = S_PRS;
              end else begin
                w_db_nx[i]    = r_db[i] + 10'd1;
                w_state_nx[i] = S_PRESS_PEND;
              end
            end else begin
              w_db_nx[i]    = '0;
              w_state_nx[i] = S_REL;
            end
          end
          S_PRS, S_REL_PEND: begin
            if (!r_sync2[i]) begin
              if (r_db[i] + 10'd1 == ST) begin
                w_stable_nx[i]  = 1'b0;
                w_release_nx[i] = 1'b1;
                w_db_nx[i]      = '0;
                w_hold_nx[i]    = '0;
                w_state_nx[i]   = S_REL;
              end else begin
                w_db_nx[i]    = r_db[i] + 10'd1;
                w_state_nx[i] = S_REL_PEND;
              end
            end else begin
              w_db_nx[i]    = '0;
              w_state_nx[i] = S_PRS;
            end
          end
          default: w_state_nx[i] = S_REL;
        endcase
      end
    end
  end

  always_ff @(posedge clk25mhz) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_tick_d  <= 1'b0;
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      for (int i = 0; i < N; i++) begin
        r_state[i] <= S_REL;
        r_db[i]    <= '0;
        r_hold[i]  <= '0;
      end
    end else begin
      r_sync1   <= bus.btn_raw;
      r_sync2   <= r_sync1;
      r_tick_d  <= bus.tick;
      r_stable  <= w_stable_nx;
      r_press   <= w_press_nx;
      r_release <= w_release_nx;
      r_long    <= w_long_nx;
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_state_nx[i];
        r_db[i]    <= w_db_nx[i];
        r_hold[i]  <= w_hold_nx[i];
      end
    end
  end

  assign bus.btn_stable  = r_stable;
  assign bus.btn_press   = r_press;
  assign bus.btn_release = r_release;
  assign bus.btn_long    = r_long;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: STABLE_TICKS=4,
// HOLD_TICKS=10, strobe 6 high out of 20 cycles.
module tb_button_debouncer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic clr_req;
  int   pc [4];
  int   rc [4];
  int   lc [4];
  int   bad_rst;

  button_debouncer_if #(.N(4)) bus ();

  button_debouncer #(
    .N(4),
    .STABLE_TICKS(4),
    .HOLD_TICKS(10)
  ) dut (
    .clk25mhz(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 4; i++) begin
        pc[i] = 0;
        rc[i] = 0;
        lc[i] = 0;
      end
      bad_rst = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pc[i] = pc[i] + int'(bus.btn_press[i]);
        rc[i] = rc[i] + int'(bus.btn_release[i]);
        lc[i] = lc[i] + int'(bus.btn_long[i]);
      end
      if (!rst_n && (bus.btn_stable | bus.btn_press
                     | bus.btn_release | bus.btn_long) != 4'h0)
        bad_rst = bad_rst + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr();
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  // one strobe period: rise is seen at the 4th posedge
  task automatic step();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.tick = (i >= 3 && i < 9);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    clr_req     = 1'b1;
    rst_n       = 1'b0;
    bus.tick    = 1'b0;
    bus.btn_raw = 4'hF;
    @(negedge clk);
    @(negedge clk);
    clr_req = 1'b0;

    // reset with activity on all inputs
    step();
    chk("rst_outputs_zero", 32'(bad_rst), 0);
    chk("rst_stable", 32'(bus.btn_stable), 0);
    rst_n = 1'b1;
    steps(3);
    chk("post_rst_3ticks", 32'(bus.btn_stable), 0);
    step();
    chk("post_rst_4ticks", 32'(bus.btn_stable), 32'hF);
    chk("post_rst_press0", 32'(pc[0]), 1);
    chk("post_rst_press3", 32'(pc[3]), 1);
    bus.btn_raw = 4'h0;
    steps(4);
    chk("all_release", 32'(bus.btn_stable), 0);
    chk("all_release_rc2", 32'(rc[2]), 1);
    clr();

    // clean press on bit 0
    bus.btn_raw = 4'h1;
    steps(3);
    chk("clean_3", 32'(bus.btn_stable), 0);
    chk("clean_3_press", 32'(pc[0]), 0);
    step();
    chk("clean_4", 32'(bus.btn_stable), 32'h1);
    chk("clean_press_once", 32'(pc[0]), 1);
    chk("clean_others", 32'(pc[1] + pc[2] + pc[3]), 0);
    bus.btn_raw = 4'h0;
    steps(4);
    chk("clean_rel", 32'(rc[0]), 1);
    chk("clean_no_long", 32'(lc[0]), 0);
    clr();

    // bounce on bit 1: 1,1,1,0 then 1 held
    bus.btn_raw = 4'h2;
    steps(3);
    bus.btn_raw = 4'h0;
    step();
    bus.btn_raw = 4'h2;
    steps(3);
    chk("bounce_7", 32'(pc[1]), 0);
    chk("bounce_7_stable", 32'(bus.btn_stable), 0);
    step();
    chk("bounce_8", 32'(pc[1]), 1);
    chk("bounce_8_stable", 32'(bus.btn_stable), 32'h2);
    bus.btn_raw = 4'h0;
    steps(4);
    clr();

    // long press on bit 2, then re-press
    bus.btn_raw = 4'h4;
    steps(4);
    chk("long_press", 32'(pc[2]), 1);
    steps(9);
    chk("long_before", 32'(lc[2]), 0);
    step();
    chk("long_at10", 32'(lc[2]), 1);
    steps(16);
    chk("long_no_repeat", 32'(lc[2]), 1);
    bus.btn_raw = 4'h0;
    steps(3);
    chk("long_rel_3", 32'(rc[2]), 0);
    step();
    chk("long_rel_4", 32'(rc[2]), 1);
    bus.btn_raw = 4'h4;
    steps(4);
    chk("repress", 32'(pc[2]), 2);
    steps(10);
    chk("relong", 32'(lc[2]), 2);
    bus.btn_raw = 4'h0;
    steps(4);
    clr();

    // stretched strobe with bit 3 pressed
    bus.btn_raw = 4'h8;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      bus.tick = (i >= 3 && i < 103);
    end
    chk("stretch_stable", 32'(bus.btn_stable), 0);
    steps(2);
    chk("stretch_plus2", 32'(bus.btn_stable), 0);
    step();
    chk("stretch_plus3", 32'(bus.btn_stable), 32'h8);
    bus.btn_raw = 4'h0;
    steps(4);
    clr();

    // reset just before the 4th qualifying strobe of a press
    bus.btn_raw = 4'h1;
    steps(3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b0;
      if (i == 9) rst_n = 1'b1;
      bus.tick = (i >= 3 && i < 9);
    end
    chk("midrst_no_press", 32'(pc[0]), 0);
    chk("midrst_outputs", 32'(bad_rst), 0);
    steps(3);
    chk("midrst_restart3", 32'(bus.btn_stable), 0);
    step();
    chk("midrst_restart4", 32'(bus.btn_stable), 32'h1);
    chk("midrst_press", 32'(pc[0]), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
